// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: schedule FSM states, round counts and the
// small-sigma rotate/shift amounts for both word widths.
package sha2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int ROUNDS_256 = 64;
    localparam int ROUNDS_512 = 80;

    localparam int S0_ROT_A_256 = 7;
    localparam int S0_ROT_B_256 = 18;
    localparam int S0_SHR_256   = 3;
    localparam int S1_ROT_A_256 = 17;
    localparam int S1_ROT_B_256 = 19;
    localparam int S1_SHR_256   = 10;

    localparam int S0_ROT_A_512 = 1;
    localparam int S0_ROT_B_512 = 8;
    localparam int S0_SHR_512   = 7;
    localparam int S1_ROT_A_512 = 19;
    localparam int S1_ROT_B_512 = 61;
    localparam int S1_SHR_512   = 6;

    function automatic int rounds_for(input int word_w);
        return (word_w == 64) ? ROUNDS_512 : ROUNDS_256;
    endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational small-sigma pair (s0, s1) of one schedule word.
module sha2_sigma
    import sha2_pkg::*;
#(
    parameter int WORD_W = 32
)(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] s0,
    output logic [WORD_W-1:0] s1
);

    localparam bit W64 = (WORD_W == 64);
    localparam int R0A = W64 ? S0_ROT_A_512 : S0_ROT_A_256;
    localparam int R0B = W64 ? S0_ROT_B_512 : S0_ROT_B_256;
    localparam int SH0 = W64 ? S0_SHR_512   : S0_SHR_256;
    localparam int R1A = W64 ? S1_ROT_A_512 : S1_ROT_A_256;
    localparam int R1B = W64 ? S1_ROT_B_512 : S1_ROT_B_256;
    localparam int SH1 = W64 ? S1_SHR_512   : S1_SHR_256;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
        return (v >> n) | (v << (WORD_W - n));
    endfunction

    assign s0 = rotr(x, R0A) ^ rotr(x, R0B) ^ (x >> SH0);
    assign s1 = rotr(x, R1A) ^ rotr(x, R1B) ^ (x >> SH1);

endmodule

// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule: loads a 16-word block and streams W[0..ROUNDS-1]
// over valid/ready, with abort and zero-bubble back-to-back block loads.
module sha2_msg_sched
    import sha2_pkg::*;
#(
    parameter  int WORD_W = 32,
    localparam int ROUNDS = rounds_for(WORD_W),
    localparam int IDX_W  = 7
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 blk_valid,
    output logic                 blk_ready,
    input  logic [16*WORD_W-1:0] blk,
    input  logic                 abort,
    output logic                 w_valid,
    input  logic                 w_ready,
    output logic [WORD_W-1:0]    w,
    output logic [IDX_W-1:0]     w_idx,
    output logic                 w_last,
    output logic                 busy
);

    generate
        if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
            $error("sha2_msg_sched: WORD_W must be 32 or 64");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

    sched_state_t      state_reg;
    logic [IDX_W-1:0]  ctr_reg;
    logic [WORD_W-1:0] win_reg [16];

    logic [WORD_W-1:0] sig_s0 [2];
    logic [WORD_W-1:0] sig_s1 [2];
    logic [WORD_W-1:0] wnew;
    logic              run;
    logic              last_w;
    logic              hs;
    logic              load;
    logic              shift;

    assign run    = (state_reg == RUN);
    assign last_w = run && (ctr_reg == LAST_IDX);
    assign hs     = run && w_ready && !abort;
    assign load   = (!run && blk_valid) || (hs && last_w && blk_valid);
    assign shift  = hs && !last_w;

    // Instance 0 supplies s0(win[1]), instance 1 supplies s1(win[14]).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sigma
            localparam int TAP = (gi == 0) ? 1 : 14;
            sha2_sigma #(.WORD_W(WORD_W)) u_sigma (
                .x  (win_reg[TAP]),
                .s0 (sig_s0[gi]),
                .s1 (sig_s1[gi])
            );
        end
    endgenerate

    assign wnew = win_reg[0] + sig_s0[0] + win_reg[9] + sig_s1[1];

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_win
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    win_reg[gi] <= '0;
                end else if (load) begin
                    win_reg[gi] <= blk[16*WORD_W-1-gi*WORD_W -: WORD_W];
                end else if (shift) begin
                    if (gi == 15) begin
                        win_reg[gi] <= wnew;
                    end else begin
                        win_reg[gi] <= win_reg[(gi < 15) ? gi + 1 : gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ctr_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (blk_valid) begin
                        state_reg <= RUN;
                        ctr_reg   <= '0;
                    end
                end
                RUN: begin
                    // Abort takes priority: a word handshaked in the same cycle is dropped.
                    if (abort) begin
                        state_reg <= IDLE;
                        ctr_reg   <= '0;
                    end else if (w_ready) begin
                        if (ctr_reg == LAST_IDX) begin
                            ctr_reg   <= '0;
                            state_reg <= blk_valid ? RUN : IDLE;
                        end else begin
                            ctr_reg <= ctr_reg + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ctr_reg   <= '0;
                end
            endcase
        end
    end

    assign blk_ready = !rst_n || !run || (last_w && w_ready && !abort);
    assign w_valid   = run;
    assign busy      = run;
    assign w         = win_reg[0];
    assign w_idx     = ctr_reg;
    assign w_last    = last_w;

endmodule
